// File: rtl/arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package arb_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_GNT_I, ARB_GNT_D} arb_state_t;
    typedef enum logic {PORT_I, PORT_D} arb_port_t;

    localparam logic ARB_ERR_RDATA = '0;

endpackage

// File: rtl/arb_wait_timer.sv
// Per-transaction wait counter; o_expire fires on the last allowed wait cycle.
// TIMEOUT=0 removes the counter entirely and never expires.
module arb_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    generate
        if (TIMEOUT > 0) begin : g_timer
            localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
            logic [CW-1:0] r_cnt;

            always_ff @(posedge clk) begin
                if (rst || i_clr) begin
                    r_cnt <= '0;
                end else if (i_en) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            // Expiring on the TIMEOUT-th wait lets the abort ack land one cycle later.
            assign o_expire = i_en && (r_cnt == CW'(TIMEOUT - 1));
        end else begin : g_off
            logic w_unused;
            assign w_unused = &{1'b0, clk, rst, i_clr, i_en};
            assign o_expire = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory between the fetch (i_*) and data (d_*) ports.
// Define ARB_ROUND_ROBIN_EN to alternate on conflicts instead of fixed data priority.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_ack,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    output logic          err,
    output logic          stall,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ready
);

    arb_state_t    r_state, w_state_nxt;
    arb_port_t     w_pick;
    logic          w_in_gnt, w_done, w_expire, w_decide, w_gnt;
    logic          w_i_cand, w_d_cand, w_tmr_clr, w_tmr_en;
    logic          r_i_ack, r_d_ack, r_err, r_m_req, r_m_we;
    logic [AW-1:0] r_m_addr;
    logic [DW-1:0] r_m_wdata, r_i_rdata, r_d_rdata;

    assign w_in_gnt  = (r_state != ARB_IDLE);
    assign w_tmr_en  = w_in_gnt && !m_ready;
    assign w_tmr_clr = !w_in_gnt || w_done;

    arb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (w_tmr_clr),
        .i_en     (w_tmr_en),
        .o_expire (w_expire)
    );

    assign w_done   = w_in_gnt && (m_ready || w_expire);
    assign w_decide = !w_in_gnt || w_done;

    // A port whose ack is showing, or which is finishing now, still holds req high.
    assign w_i_cand = i_req && !r_i_ack && (r_state != ARB_GNT_I);
    assign w_d_cand = d_req && !r_d_ack && (r_state != ARB_GNT_D);
    assign w_gnt    = w_decide && (w_i_cand || w_d_cand);

`ifdef ARB_ROUND_ROBIN_EN
    arb_port_t r_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= PORT_I;
        end else if (w_gnt) begin
            r_last <= w_pick;
        end
    end
`endif

    always_comb begin
        w_pick      = PORT_I;
        w_state_nxt = r_state;
`ifdef ARB_ROUND_ROBIN_EN
        if (w_i_cand && w_d_cand) begin
            w_pick = (r_last == PORT_D) ? PORT_I : PORT_D;
        end else if (w_d_cand) begin
            w_pick = PORT_D;
        end
`else
        if (w_d_cand) begin
            w_pick = PORT_D;
        end
`endif
        if (w_decide) begin
            if (!w_gnt) begin
                w_state_nxt = ARB_IDLE;
            end else if (w_pick == PORT_D) begin
                w_state_nxt = ARB_GNT_D;
            end else begin
                w_state_nxt = ARB_GNT_I;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_i_ack   <= 1'b0;
            r_d_ack   <= 1'b0;
            r_err     <= 1'b0;
            r_m_req   <= 1'b0;
            r_m_we    <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            r_i_ack <= w_done && (r_state == ARB_GNT_I);
            r_d_ack <= w_done && (r_state == ARB_GNT_D);
            r_err   <= w_done && !m_ready;
            if (w_done && (r_state == ARB_GNT_I)) begin
                r_i_rdata <= m_ready ? m_rdata : {DW{ARB_ERR_RDATA}};
            end
            if (w_done && (r_state == ARB_GNT_D)) begin
                r_d_rdata <= m_ready ? m_rdata : {DW{ARB_ERR_RDATA}};
            end
            // Re-granting in the completion cycle keeps m_req high across back-to-back ports.
            if (w_decide) begin
                r_m_req <= w_gnt;
                r_m_we  <= w_gnt && (w_pick == PORT_D) && d_we;
                if (w_gnt) begin
                    if (w_pick == PORT_D) begin
                        r_m_addr  <= d_addr;
                        r_m_wdata <= d_wdata;
                    end else begin
                        r_m_addr  <= i_addr;
                    end
                end
            end
        end
    end

    assign i_ack   = r_i_ack;
    assign d_ack   = r_d_ack;
    assign err     = r_err;
    assign i_rdata = r_i_rdata;
    assign d_rdata = r_d_rdata;
    assign m_req   = r_m_req;
    assign m_we    = r_m_we;
    assign m_addr  = r_m_addr;
    assign m_wdata = r_m_wdata;
    assign stall   = (i_req && !r_i_ack) || (d_req && !r_d_ack);

endmodule
